prbs_checker: RTL and testbench

- Downstream receiver for the 4-lane PRBS generator output: consumes the 4-bit parallel PRBS word every clock and self-synchronises a local LFSR to the incoming stream.
- Reports lock status and counts bit errors (saturating), and flags loss of lock.
- Used for FPGA loopback/BER testing of the generator and any link it drives.

---
 rtl/prbs_checker.sv | 200 ++++++++++++++++++++
 tb/tb_prbs_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with lock and BER counters.
// Define PRBS_CHK_BIT_CNT_EN to add the bit_cnt checked-bit counter output.
module prbs_checker #(
  parameter int ORDER       = 7,
  parameter int TAP_A       = 7,
  parameter int TAP_B       = 6,
  parameter int LANES       = 4,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [LANES-1:0] din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             lock,
  output logic             err_word,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sat,
  output logic             lock_lost
`ifdef PRBS_CHK_BIT_CNT_EN
  ,output logic [31:0]     bit_cnt
`endif
);

  localparam int SEED_N = (ORDER + LANES - 1) / LANES;
  localparam int SC_W   = $clog2(SEED_N + 1);
  localparam int PC_W   = $clog2(LANES + 1);
  localparam int SUM_W  = CNT_W + PC_W;
  localparam int BR_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_CHECK
  } state_e;

  state_e           state_q, state_d;
  logic [ORDER-1:0] hist_q, hist_d;
  logic [SC_W-1:0]  seed_cnt_q, seed_cnt_d;
  logic [BR_W-1:0]  bad_run_q, bad_run_d;
  logic             err_word_q, err_word_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sat_q, err_sat_d;
  logic             lock_lost_q, lock_lost_d;

  logic [ORDER-1:0] hist_seed, hist_pred;
  logic [LANES-1:0] pred, mism;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic             chk, bad_hit, seed_done;

  // hist[0] is the newest bit; b[k] = b[k-TAP_A] ^ b[k-TAP_B]
  always_comb begin
    hist_pred = hist_q;
    pred      = '0;
    for (int i = 0; i < LANES; i++) begin
      pred[i]   = hist_pred[TAP_A-1] ^ hist_pred[TAP_B-1];
      hist_pred = {hist_pred[ORDER-2:0], pred[i]};
    end
  end

  always_comb begin
    hist_seed = hist_q;
    for (int i = 0; i < LANES; i++) begin
      hist_seed = {hist_seed[ORDER-2:0], din[i]};
    end
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + PC_W'(mism[i]);
    end
  end

  assign mism      = din ^ pred;
  assign chk       = en && din_valid && (state_q == S_CHECK);
  assign bad_hit   = (|mism) && (bad_run_q == BR_W'(LOSS_THRESH - 1));
  assign seed_done = (seed_cnt_q == SC_W'(SEED_N - 1));
  assign sum       = SUM_W'(err_cnt_q) + SUM_W'(pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_SEED;
        S_SEED:  if (din_valid && seed_done) state_d = S_CHECK;
        S_CHECK: if (din_valid && bad_hit) state_d = S_SEED;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lock = (state_q == S_CHECK);
  end

  always_comb begin
    hist_d      = hist_q;
    seed_cnt_d  = seed_cnt_q;
    bad_run_d   = bad_run_q;
    err_word_d  = 1'b0;
    lock_lost_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    err_sat_d   = err_sat_q;
    if (!en || state_q == S_IDLE) begin
      hist_d     = '0;
      seed_cnt_d = '0;
      bad_run_d  = '0;
    end else if (din_valid && state_q == S_SEED) begin
      hist_d     = hist_seed;
      seed_cnt_d = seed_done ? '0 : seed_cnt_q + SC_W'(1);
    end else if (chk) begin
      // predicted bits go into history so one flipped bit counts once
      hist_d     = hist_pred;
      err_word_d = |mism;
      bad_run_d  = (|mism) ? bad_run_q + BR_W'(1) : '0;
      if (bad_hit) begin
        bad_run_d   = '0;
        seed_cnt_d  = '0;
        lock_lost_d = 1'b1;
      end
      if (sum[SUM_W-1:CNT_W] != '0) begin
        err_cnt_d = '1;
      end else begin
        err_cnt_d = sum[CNT_W-1:0];
      end
      err_sat_d = err_sat_q | (&err_cnt_d);
    end
    if (clr_cnt) begin
      err_cnt_d = '0;
      err_sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      bad_run_q   <= '0;
      err_word_q  <= 1'b0;
      err_cnt_q   <= '0;
      err_sat_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      bad_run_q   <= bad_run_d;
      err_word_q  <= err_word_d;
      err_cnt_q   <= err_cnt_d;
      err_sat_q   <= err_sat_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign err_word  = err_word_q;
  assign err_cnt   = err_cnt_q;
  assign err_sat   = err_sat_q;
  assign lock_lost = lock_lost_q;

`ifdef PRBS_CHK_BIT_CNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;
  logic [32:0] bit_sum;

  assign bit_sum = {1'b0, bit_cnt_q} + 33'(LANES);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (chk) begin
      bit_cnt_d = bit_sum[32] ? '1 : bit_sum[31:0];
    end
    if (clr_cnt) begin
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed PRBS7 stream with injected errors, CNT_W=4.
// Covers lock, error counting, loss of lock, saturation, clear, resets.
module tb_prbs_checker;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [3:0]    din;
  logic          din_valid;
  logic          clr_cnt;
  logic          lock;
  logic          err_word;
  logic [CW-1:0] err_cnt;
  logic          err_sat;
  logic          lock_lost;
`ifdef PRBS_CHK_BIT_CNT_EN
  logic [31:0]   bit_cnt;
`endif

  logic seq [0:16383];
  int   wp;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  prbs_checker #(
    .ORDER(7),
    .TAP_A(7),
    .TAP_B(6),
    .LANES(4),
    .LOSS_THRESH(4),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .din(din),
    .din_valid(din_valid),
    .clr_cnt(clr_cnt),
    .lock(lock),
    .err_word(err_word),
    .err_cnt(err_cnt),
    .err_sat(err_sat),
    .lock_lost(lock_lost)
`ifdef PRBS_CHK_BIT_CNT_EN
    ,.bit_cnt(bit_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] word_at(input int w);
    return {seq[4*w+3], seq[4*w+2], seq[4*w+1], seq[4*w]};
  endfunction

  task automatic send(input logic [3:0] flip);
    din       = word_at(wp) ^ flip;
    din_valid = 1'b1;
    wp++;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 4'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic relock(input string tag);
    send(4'b0000);
    chk({tag, "_lock_w1"}, 32'(lock), 0);
    send(4'b0000);
    chk({tag, "_lock_w2"}, 32'(lock), 1);
  endtask

  task automatic clean_run(input string tag, input int n);
    int ew;
    ew = 0;
    for (int i = 0; i < n; i++) begin
      if (i == n / 2) begin
        for (int g = 0; g < 5; g++) begin
          idle(1);
          chk({tag, "_gap_errw"}, 32'(err_word), 0);
          chk({tag, "_gap_lock"}, 32'(lock), 1);
        end
      end
      send(4'b0000);
      if (err_word !== 1'b0) ew++;
    end
    chk({tag, "_err_word_seen"}, 32'(ew), 0);
    chk({tag, "_lock"}, 32'(lock), 1);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
`ifdef PRBS_CHK_BIT_CNT_EN
    chk({tag, "_bit_cnt"}, bit_cnt, 32'(4 * n));
`endif
  endtask

  initial begin
    for (int k = 0; k < 7; k++) seq[k] = 1'b1;
    for (int k = 7; k < 16384; k++) seq[k] = seq[k-7] ^ seq[k-6];
    wp        = 0;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    din       = 4'h0;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;

    idle(2);
    chk("rst_lock", 32'(lock), 0);
    chk("rst_err_word", 32'(err_word), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_err_sat", 32'(err_sat), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
`ifdef PRBS_CHK_BIT_CNT_EN
    chk("rst_bit_cnt", bit_cnt, 0);
`endif
    rst_n = 1'b1;
    en    = 1'b1;
    idle(1);
    chk("seed_entry_lock", 32'(lock), 0);
    relock("lock1");
    clean_run("clean1", 1000);

    send(4'b0100);
    chk("flip2_err_word", 32'(err_word), 1);
    chk("flip2_err_cnt", 32'(err_cnt), 1);
    chk("flip2_lock", 32'(lock), 1);
    send(4'b0000);
    chk("flip2_next_err_word", 32'(err_word), 0);
    chk("flip2_next_err_cnt", 32'(err_cnt), 1);

    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    chk("clr_idle_err_cnt", 32'(err_cnt), 0);
    chk("clr_idle_lock", 32'(lock), 1);

    send(4'b0001);
    chk("run1_cnt", 32'(err_cnt), 1);
    chk("run1_lock", 32'(lock), 1);
    send(4'b0010);
    chk("run2_cnt", 32'(err_cnt), 2);
    send(4'b1000);
    chk("run3_cnt", 32'(err_cnt), 3);
    chk("run3_lock_lost", 32'(lock_lost), 0);
    chk("run3_lock", 32'(lock), 1);
    send(4'b0100);
    chk("run4_cnt", 32'(err_cnt), 4);
    chk("run4_lock_lost", 32'(lock_lost), 1);
    chk("run4_lock", 32'(lock), 0);
    relock("relock1");
    chk("relock1_lock_lost", 32'(lock_lost), 0);
    chk("relock1_cnt", 32'(err_cnt), 4);

    send(4'b0111);
    chk("sat1_cnt", 32'(err_cnt), 7);
    send(4'b0111);
    chk("sat2_cnt", 32'(err_cnt), 10);
    send(4'b0111);
    chk("sat3_cnt", 32'(err_cnt), 13);
    chk("sat3_err_sat", 32'(err_sat), 0);
    send(4'b0111);
    chk("sat4_cnt", 32'(err_cnt), 15);
    chk("sat4_err_sat", 32'(err_sat), 1);
    chk("sat4_lock_lost", 32'(lock_lost), 1);
    relock("relock2");
    send(4'b0111);
    chk("sat5_cnt", 32'(err_cnt), 15);
    chk("sat5_err_sat", 32'(err_sat), 1);
    clr_cnt = 1'b1;
    send(4'b0111);
    clr_cnt = 1'b0;
    chk("clr_wins_cnt", 32'(err_cnt), 0);
    chk("clr_wins_sat", 32'(err_sat), 0);
    chk("clr_wins_err_word", 32'(err_word), 1);
    chk("clr_wins_lock", 32'(lock), 1);
    send(4'b0000);
    chk("post_clr_cnt", 32'(err_cnt), 0);

    send(4'b0001);
    chk("pre_en_cnt", 32'(err_cnt), 1);
    en = 1'b0;
    idle(1);
    chk("en0_lock", 32'(lock), 0);
    chk("en0_cnt", 32'(err_cnt), 1);
    en = 1'b1;
    idle(1);
    relock("relock3");
    send(4'b1000);
    chk("pre_rst_err_word", 32'(err_word), 1);
    chk("pre_rst_cnt", 32'(err_cnt), 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_lock", 32'(lock), 0);
    chk("arst_err_word", 32'(err_word), 0);
    chk("arst_cnt", 32'(err_cnt), 0);
    chk("arst_sat", 32'(err_sat), 0);
    chk("arst_lock_lost", 32'(lock_lost), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    relock("relock4");
    clean_run("clean2", 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
